// File: rtl/delay_test_pkg.sv
// Shared definitions for the delay-test frame generator and checker:
// frame byte offsets, default EtherType and the checker FSM state encoding.
package delay_test_pkg;

  localparam int unsigned ETH_TYPE_OFS = 12;
  localparam int unsigned SEQ_OFS      = 14;
  localparam int unsigned TS_OFS       = 18;
  localparam int unsigned SEQ_BYTES    = 4;

  localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_TS,
    ST_PAYLOAD,
    ST_DROP
  } dt_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/delay_frame_checker.sv
// Parses delay-test frames from the MAC RX client stream and reports one-way delay,
// sequence gaps and statistics. Optional min/max tracking: DELAY_FRAME_CHECKER_MINMAX_EN.
module delay_frame_checker
  import delay_test_pkg::*;
#(
  parameter int unsigned TS_W      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] ETHERTYPE = DEFAULT_ETHERTYPE
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic [TS_W-1:0]  cur_time,
  input  logic [7:0]       mac_rx_data,
  input  logic             mac_rx_dvld,
  input  logic             mac_rx_goodframe,
  input  logic             mac_rx_badframe,
  output logic             res_valid,
  output logic [TS_W-1:0]  res_delay,
  output logic [31:0]      res_seq,
  output logic             res_seq_err,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_ignored,
  output logic [CNT_W-1:0] cnt_seq_err
`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
  ,
  input  logic             stats_clear,
  output logic [TS_W-1:0]  delay_min,
  output logic [TS_W-1:0]  delay_max
`endif
);

  localparam int unsigned TS_BYTES = TS_W / 8;
  localparam logic [7:0] ETH_FIRST = 8'(ETH_TYPE_OFS);
  localparam logic [7:0] ETH_LAST  = 8'(ETH_TYPE_OFS + 1);
  localparam logic [7:0] SEQ_LAST  = 8'(SEQ_OFS + SEQ_BYTES - 1);
  localparam logic [7:0] TS_LAST   = 8'(TS_OFS + TS_BYTES - 1);

  dt_state_e         state_q, state_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       ethertype_q, ethertype_d;
  logic [31:0]       seq_q, seq_d;
  logic [TS_W-1:0]   tx_ts_q, tx_ts_d;
  logic [TS_W-1:0]   rx_start_q, rx_start_d;
  logic              parsed_q, parsed_d;
  logic              seq_valid_q;
  logic [31:0]       expected_q;

  logic              report_c, ignore_c, bad_c, seq_err_c, stats_clr_c;
  logic [15:0]       ethertype_shift_c;

  assign ethertype_shift_c = {ethertype_q[7:0], mac_rx_data};
  assign seq_err_c         = report_c && seq_valid_q && (seq_q != expected_q);

`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
  assign stats_clr_c = stats_clear;
`else
  assign stats_clr_c = 1'b0;
`endif

  // State and parse registers
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      byte_cnt_q  <= '0;
      ethertype_q <= '0;
      seq_q       <= '0;
      tx_ts_q     <= '0;
      rx_start_q  <= '0;
      parsed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      ethertype_q <= ethertype_d;
      seq_q       <= seq_d;
      tx_ts_q     <= tx_ts_d;
      rx_start_q  <= rx_start_d;
      parsed_q    <= parsed_d;
    end
  end

  // Next-state and parse control; an end pulse outranks any byte in the same cycle
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    ethertype_d = ethertype_q;
    seq_d       = seq_q;
    tx_ts_d     = tx_ts_q;
    rx_start_d  = rx_start_q;
    parsed_d    = parsed_q;
    report_c    = 1'b0;
    ignore_c    = 1'b0;
    bad_c       = 1'b0;

    if (state_q == ST_SYNC) begin
      if (!mac_rx_dvld) state_d = ST_IDLE;
    end else if (mac_rx_goodframe || mac_rx_badframe) begin
      state_d  = ST_IDLE;
      parsed_d = 1'b0;
      if (mac_rx_badframe)  bad_c    = 1'b1;
      else if (parsed_q)    report_c = 1'b1;
      else                  ignore_c = 1'b1;
    end else if (mac_rx_dvld) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
      case (state_q)
        ST_IDLE: begin
          rx_start_d = cur_time;
          byte_cnt_d = 8'd1;
          parsed_d   = 1'b0;
          state_d    = ST_HDR;
        end
        ST_HDR: begin
          if (byte_cnt_q >= ETH_FIRST) ethertype_d = ethertype_shift_c;
          if (byte_cnt_q == ETH_LAST)
            state_d = (ethertype_shift_c == ETHERTYPE) ? ST_SEQ : ST_DROP;
        end
        ST_SEQ: begin
          seq_d = {seq_q[23:0], mac_rx_data};
          if (byte_cnt_q == SEQ_LAST) state_d = ST_TS;
        end
        ST_TS: begin
          tx_ts_d = TS_W'({tx_ts_q, mac_rx_data});
          if (byte_cnt_q == TS_LAST) begin
            state_d  = ST_PAYLOAD;
            parsed_d = 1'b1;
          end
        end
        default: byte_cnt_d = byte_cnt_q;
      endcase
    end
  end

  // Result strobe and sequence tracking
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_delay   <= '0;
      res_seq     <= '0;
      res_seq_err <= 1'b0;
      seq_valid_q <= 1'b0;
      expected_q  <= '0;
    end else begin
      res_valid <= report_c;
      if (report_c) begin
        res_delay   <= rx_start_q - tx_ts_q;
        res_seq     <= seq_q;
        res_seq_err <= seq_err_c;
        expected_q  <= seq_q + 32'd1;
        seq_valid_q <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_good (
    .clk(rx_clk), .reset(reset), .inc(report_c), .clr(stats_clr_c), .count(cnt_good)
  );
  sat_counter #(.W(CNT_W)) u_cnt_bad (
    .clk(rx_clk), .reset(reset), .inc(bad_c), .clr(stats_clr_c), .count(cnt_bad)
  );
  sat_counter #(.W(CNT_W)) u_cnt_ignored (
    .clk(rx_clk), .reset(reset), .inc(ignore_c), .clr(stats_clr_c), .count(cnt_ignored)
  );
  sat_counter #(.W(CNT_W)) u_cnt_seq_err (
    .clk(rx_clk), .reset(reset), .inc(seq_err_c), .clr(stats_clr_c), .count(cnt_seq_err)
  );

`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
  // Min/max follow the reported delay one cycle behind the strobe
  always_ff @(posedge rx_clk) begin
    if (reset || stats_clear) begin
      delay_min <= {TS_W{1'b1}};
      delay_max <= '0;
    end else if (res_valid) begin
      if (res_delay < delay_min) delay_min <= res_delay;
      if (res_delay > delay_max) delay_max <= res_delay;
    end
  end
`endif

endmodule

// File: tb/tb_delay_frame_checker.sv
// Directed, table-driven bench for delay_frame_checker (TS_W = 32).
// Min/max checks are compiled in when DELAY_FRAME_CHECKER_MINMAX_EN is defined.
module tb_delay_frame_checker;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic [31:0] cur_time;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_dvld;
  logic        mac_rx_goodframe;
  logic        mac_rx_badframe;
  logic        res_valid;
  logic [31:0] res_delay;
  logic [31:0] res_seq;
  logic        res_seq_err;
  logic [31:0] cnt_good, cnt_bad, cnt_ignored, cnt_seq_err;
`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
  logic        stats_clear;
  logic [31:0] delay_min, delay_max;
`endif

  int checks = 0;
  int errors = 0;

  logic        got_v1, got_v2, got_err;
  logic [31:0] got_delay, got_seq;

  always #5 rx_clk = ~rx_clk;

  delay_frame_checker #(.TS_W(32), .CNT_W(32), .ETHERTYPE(16'h88B5)) dut (
    .rx_clk(rx_clk),
    .reset(reset),
    .cur_time(cur_time),
    .mac_rx_data(mac_rx_data),
    .mac_rx_dvld(mac_rx_dvld),
    .mac_rx_goodframe(mac_rx_goodframe),
    .mac_rx_badframe(mac_rx_badframe),
    .res_valid(res_valid),
    .res_delay(res_delay),
    .res_seq(res_seq),
    .res_seq_err(res_seq_err),
    .cnt_good(cnt_good),
    .cnt_bad(cnt_bad),
    .cnt_ignored(cnt_ignored),
    .cnt_seq_err(cnt_seq_err)
`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
    ,
    .stats_clear(stats_clear),
    .delay_min(delay_min),
    .delay_max(delay_max)
`endif
  );

  typedef struct {
    logic [15:0] et;
    logic [31:0] sq;
    logic [31:0] ts;
    logic [31:0] st;
    int          len;
    int          kind;      // 0 goodframe, 1 badframe, 2 both
    logic        exp_v;
    logic [31:0] exp_delay;
    logic [31:0] exp_seq;   // held value when no result is expected
    logic        exp_err;
    logic [31:0] exp_good, exp_bad, exp_ign, exp_se;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [15:0] et,
                                            input logic [31:0] sq, input logic [31:0] ts);
    if (i == 12) return et[15:8];
    if (i == 13) return et[7:0];
    if (i >= 14 && i < 18) return sq[8*(17-i) +: 8];
    if (i >= 18 && i < 22) return ts[8*(21-i) +: 8];
    return 8'(i * 7 + 3);
  endfunction

  // Drives one frame (cur_time = st at byte 0), its end pulse, then samples
  // the cycle after the pulse and the one after that.
  task automatic send_frame(input logic [15:0] et, input logic [31:0] sq, input logic [31:0] ts,
                            input logic [31:0] st, input int len, input int kind, input int rst_at);
    for (int i = 0; i < len; i++) begin
      @(negedge rx_clk);
      mac_rx_dvld = 1'b1;
      mac_rx_data = frame_byte(i, et, sq, ts);
      cur_time    = st + 32'(i);
      if (i == rst_at) reset = 1'b1;
      else if (i == rst_at + 2) reset = 1'b0;
    end
    @(negedge rx_clk);
    mac_rx_dvld      = 1'b0;
    mac_rx_data      = 8'h00;
    mac_rx_goodframe = (kind != 1);
    mac_rx_badframe  = (kind != 0);
    @(negedge rx_clk);
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
    got_v1    = res_valid;
    got_delay = res_delay;
    got_seq   = res_seq;
    got_err   = res_seq_err;
    @(negedge rx_clk);
    got_v2 = res_valid;
  endtask

  task automatic check_counters(input string tag, input logic [31:0] g, input logic [31:0] b,
                                input logic [31:0] ig, input logic [31:0] se);
    check({tag, " cnt_good"},    64'(cnt_good),    64'(g));
    check({tag, " cnt_bad"},     64'(cnt_bad),     64'(b));
    check({tag, " cnt_ignored"}, 64'(cnt_ignored), 64'(ig));
    check({tag, " cnt_seq_err"}, 64'(cnt_seq_err), 64'(se));
  endtask

  initial begin
    vecs[0]  = '{16'h88B5, 32'd5,        32'h100,      32'h150,  64, 0, 1'b1, 32'h50,       32'd5,        1'b0, 1, 0, 0, 0};
    vecs[1]  = '{16'h88B5, 32'd6,        32'hFFFFFFF0, 32'h10,   64, 0, 1'b1, 32'h20,       32'd6,        1'b0, 2, 0, 0, 0};
    vecs[2]  = '{16'h88B5, 32'd7,        32'h0,        32'h1000, 64, 0, 1'b1, 32'h1000,     32'd7,        1'b0, 3, 0, 0, 0};
    vecs[3]  = '{16'h88B5, 32'd8,        32'h10,       32'h30,   22, 0, 1'b1, 32'h20,       32'd8,        1'b0, 4, 0, 0, 0};
    vecs[4]  = '{16'h88B5, 32'd10,       32'h5,        32'h7,    64, 0, 1'b1, 32'h2,        32'd10,       1'b1, 5, 0, 0, 1};
    vecs[5]  = '{16'h88B5, 32'd11,       32'h0,        32'h1,    64, 0, 1'b1, 32'h1,        32'd11,       1'b0, 6, 0, 0, 1};
    vecs[6]  = '{16'h88B5, 32'hFFFFFFFF, 32'h200,      32'h100,  64, 0, 1'b1, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 7, 0, 0, 2};
    vecs[7]  = '{16'h88B5, 32'd0,        32'h10,       32'h10,   64, 0, 1'b1, 32'h0,        32'd0,        1'b0, 8, 0, 0, 2};
    vecs[8]  = '{16'h0800, 32'd99,       32'h0,        32'h0,    64, 0, 1'b0, 32'h0,        32'd0,        1'b0, 8, 0, 1, 2};
    vecs[9]  = '{16'h88B5, 32'd99,       32'h0,        32'h0,    16, 0, 1'b0, 32'h0,        32'd0,        1'b0, 8, 0, 2, 2};
    vecs[10] = '{16'h88B5, 32'd1,        32'h0,        32'h0,    64, 1, 1'b0, 32'h0,        32'd0,        1'b0, 8, 1, 2, 2};
    vecs[11] = '{16'h88B5, 32'd1,        32'h0,        32'h0,    21, 0, 1'b0, 32'h0,        32'd0,        1'b0, 8, 1, 3, 2};
    vecs[12] = '{16'h88B5, 32'd1,        32'h1,        32'h41,   22, 0, 1'b1, 32'h40,       32'd1,        1'b0, 9, 1, 3, 2};
    vecs[13] = '{16'h88B5, 32'd2,        32'h0,        32'h0,    64, 2, 1'b0, 32'h0,        32'd1,        1'b0, 9, 2, 3, 2};

    reset            = 1'b1;
    cur_time         = '0;
    mac_rx_data      = '0;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
    stats_clear = 1'b0;
`endif
    repeat (3) @(negedge rx_clk);
    check("reset res_valid",   64'(res_valid),   64'(0));
    check("reset res_delay",   64'(res_delay),   64'(0));
    check("reset res_seq",     64'(res_seq),     64'(0));
    check("reset res_seq_err", 64'(res_seq_err), 64'(0));
    check_counters("reset", 0, 0, 0, 0);
`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
    check("reset delay_min", 64'(delay_min), 64'(32'hFFFFFFFF));
    check("reset delay_max", 64'(delay_max), 64'(0));
`endif
    reset = 1'b0;
    repeat (2) @(negedge rx_clk);

    for (int k = 0; k < 14; k++) begin
      send_frame(vecs[k].et, vecs[k].sq, vecs[k].ts, vecs[k].st, vecs[k].len, vecs[k].kind, -1);
      check($sformatf("vec%0d res_valid", k), 64'(got_v1), 64'(vecs[k].exp_v));
      check($sformatf("vec%0d single strobe", k), 64'(got_v2), 64'(0));
      check($sformatf("vec%0d res_seq", k), 64'(got_seq), 64'(vecs[k].exp_seq));
      if (vecs[k].exp_v) begin
        check($sformatf("vec%0d res_delay", k), 64'(got_delay), 64'(vecs[k].exp_delay));
        check($sformatf("vec%0d res_seq_err", k), 64'(got_err), 64'(vecs[k].exp_err));
      end
      check_counters($sformatf("vec%0d", k), vecs[k].exp_good, vecs[k].exp_bad,
                     vecs[k].exp_ign, vecs[k].exp_se);
    end

    // Reset asserted at byte 30, released while the frame is still streaming
    send_frame(16'h88B5, 32'd20, 32'h100, 32'h200, 64, 0, 30);
    check("midreset res_valid", 64'(got_v1), 64'(0));
    check("midreset res_seq",   64'(got_seq), 64'(0));
    check_counters("midreset", 0, 0, 0, 0);

    send_frame(16'h88B5, 32'd21, 32'h100, 32'h180, 64, 0, -1);
    check("post-reset res_valid",   64'(got_v1),    64'(1));
    check("post-reset res_delay",   64'(got_delay), 64'(32'h80));
    check("post-reset res_seq",     64'(got_seq),   64'(21));
    check("post-reset res_seq_err", 64'(got_err),   64'(0));
    check_counters("post-reset", 1, 0, 0, 0);

`ifdef DELAY_FRAME_CHECKER_MINMAX_EN
    check("minmax first min", 64'(delay_min), 64'(32'h80));
    check("minmax first max", 64'(delay_max), 64'(32'h80));
    @(negedge rx_clk);
    stats_clear = 1'b1;
    @(negedge rx_clk);
    stats_clear = 1'b0;
    check("clear1 delay_min", 64'(delay_min), 64'(32'hFFFFFFFF));
    check("clear1 delay_max", 64'(delay_max), 64'(0));
    check_counters("clear1", 0, 0, 0, 0);
    send_frame(16'h88B5, 32'd22, 32'h100, 32'h140, 64, 0, -1);
    send_frame(16'h88B5, 32'd23, 32'h100, 32'h110, 64, 0, -1);
    send_frame(16'h88B5, 32'd24, 32'h100, 32'h190, 64, 0, -1);
    check("minmax delay_min", 64'(delay_min), 64'(32'h10));
    check("minmax delay_max", 64'(delay_max), 64'(32'h90));
    check_counters("minmax", 3, 0, 0, 0);
    stats_clear = 1'b1;
    @(negedge rx_clk);
    stats_clear = 1'b0;
    check("clear2 delay_min", 64'(delay_min), 64'(32'hFFFFFFFF));
    check("clear2 delay_max", 64'(delay_max), 64'(0));
    check_counters("clear2", 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
